// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit: op codes, FSM states and
// big-endian byte-lane masks (mask bit 3 is bits [31:24]).
package store_merge_unit_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] OP_SB  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [3:0] LANE_BYTE0   = 4'b1000;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_WORD    = 4'b1111;
    localparam logic [3:0] LANE_NONE    = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [3:0] laneMask(input logic [1:0] op, input logic [1:0] byteAddr);
        logic [3:0] mask;
        mask = LANE_NONE;
        case (op)
            OP_SB:   mask = LANE_BYTE0 >> byteAddr;
            OP_SH:   mask = byteAddr[1] ? LANE_HALF_LO : LANE_HALF_HI;
            OP_SW:   mask = LANE_WORD;
            default: mask = LANE_NONE;
        endcase
        return mask;
    endfunction

    function automatic logic isMisaligned(input logic [1:0] op, input logic [1:0] byteAddr);
        logic bad;
        bad = 1'b1;
        case (op)
            OP_SB:   bad = 1'b0;
            OP_SH:   bad = byteAddr[0];
            OP_SW:   bad = (byteAddr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Combinational lane merge: replaces the selected byte/halfword lanes of the
// old memory word with the narrowed store data, leaving other lanes intact.
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [1:0]        i_byteAddr,
    input  logic [WORD_W-1:0] i_oldWord,
    input  logic [WORD_W-1:0] i_newData,
    output logic [WORD_W-1:0] o_mergedWord
);

    logic [3:0]        w_mask;
    logic [WORD_W-1:0] w_laneData;

    // Replicate the narrow data across every lane so the mask alone picks the target.
    always_comb begin
        w_mask     = laneMask(i_op, i_byteAddr);
        w_laneData = i_newData;
        case (i_op)
            OP_SB:   w_laneData = {4{i_newData[7:0]}};
            OP_SH:   w_laneData = {2{i_newData[15:0]}};
            default: w_laneData = i_newData;
        endcase
        o_mergedWord = i_oldWord;
        for (int lane = 0; lane < 4; lane++) begin
            if (w_mask[lane]) begin
                o_mergedWord[lane*8 +: 8] = w_laneData[lane*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: narrows MEM-stage stores and commits them to a word-only
// RAM, using read-modify-write for byte and halfword stores.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mergeWord;
    logic              r_stReady;
    logic              r_memReq;
    logic              r_memWe;
    logic              r_done;
    logic              r_misalign;
    logic              w_stMisaligned;

    assign w_stMisaligned = isMisaligned(st_op, st_addr[1:0]);

    // Stall in the same cycle an aligned store is offered so the pipeline freezes at once.
    assign busy = (r_state == ST_READ) || (r_state == ST_WRITE) ||
                  ((r_state == ST_IDLE) && st_valid && !w_stMisaligned);

    assign st_ready = r_stReady;
    assign done     = r_done;
    assign misalign = r_misalign;
    assign mem_req  = r_memReq;
    assign mem_we   = r_memWe;
    assign mem_addr = r_addr[ADDR_W-1:2];

    store_lane_merge u_laneMerge (
        .i_op         (r_op),
        .i_byteAddr   (r_addr[1:0]),
        .i_oldWord    (r_mergeWord),
        .i_newData    (r_data),
        .o_mergedWord (mem_wdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_SB;
            r_addr      <= '0;
            r_data      <= '0;
            r_mergeWord <= '0;
            r_stReady   <= 1'b1;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (st_valid) begin
                        r_op        <= st_op;
                        r_addr      <= st_addr;
                        r_data      <= st_data;
                        r_mergeWord <= '0;
                        r_stReady   <= 1'b0;
                        if (w_stMisaligned) begin
                            r_state    <= ST_ERR;
                            r_misalign <= 1'b1;
                        end else if (st_op == OP_SW) begin
                            r_state  <= ST_WRITE;
                            r_memReq <= 1'b1;
                            r_memWe  <= 1'b1;
                        end else begin
                            r_state  <= ST_READ;
                            r_memReq <= 1'b1;
                            r_memWe  <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        r_mergeWord <= mem_rdata;
                        r_memWe     <= 1'b1;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_stReady <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_memReq  <= 1'b0;
                    r_memWe   <= 1'b0;
                    r_stReady <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Write-side counterpart of the ID-stage 16-to-32 sign extender: narrows 32-bit store data to byte/halfword/word.
- Merges the narrowed data into a word-only data memory by read-modify-write.
- Sits between the MEM pipeline stage and the word-addressed data RAM; holds the pipeline (busy) until the store commits.
- SW is a single write; SB/SH take a read then a write.

Parameters:
- ADDR_W, 32, byte-address width from the MEM stage.
- DATA_W, 32, word width; fixed at 32 (byte lanes are hardwired).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_ready  out  1  unit accepts the store (IDLE only).
- st_op  in  2  00=SB, 01=SH, 10=SW, 11=reserved.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  rt register value; SB uses [7:0], SH uses [15:0].
- busy  out  1  pipeline stall request.
- done  out  1  one-cycle pulse when the store has committed.
- misalign  out  1  one-cycle pulse; store rejected, no memory write.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W-2  word address, equal to st_addr[ADDR_W-1:2].
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  read word, valid with mem_ack on a read.
- mem_ack  in  1  request completes this cycle; latency is 1 or more cycles.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - All outputs 0 except st_ready=1.
  - Latched address, op and data are cleared.
  - Reset mid-transaction abandons the operation; mem_req drops immediately.
- Byte lanes are big-endian (MIPS):
  - addr[1:0]=0 selects bits [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - Halfword at addr[1]=0 selects [31:16]; at addr[1]=1 it selects [15:0].
- Alignment rules:
  - SH requires addr[0]=0.
  - SW requires addr[1:0]=0.
  - op=11 is treated as misaligned.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE:
  - st_ready=1, busy=0.
  - On st_valid, latch op, addr and data.
  - Misaligned -> ERR. SW -> WRITE. SB/SH -> READ.
- READ:
  - mem_req=1, mem_we=0, busy=1.
  - On mem_ack, latch mem_rdata into the merge register and go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1, busy=1.
  - mem_wdata = the merge register with the selected lane(s) replaced by st_data[7:0] or [15:0]. For SW it is st_data unchanged.
  - mem_wdata, mem_addr and mem_we stay stable until mem_ack.
  - On mem_ack -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A new store is not accepted this cycle.
- ERR: misalign=1 for one cycle, no mem_req, then IDLE.
- Latency with 1-cycle memory ack, from the accept edge to the done pulse:
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- busy asserts combinationally in IDLE when st_valid is high and the store is aligned, so the pipeline freezes in the same cycle.
- mem_ack outside READ/WRITE is ignored.
- st_valid while not IDLE is ignored; the pipeline is held by busy.
- Unselected lanes are always written back with the exact read value.

Decomposition:
- Shared package holds:
  - Op codes: OP_SB=2'b00, OP_SH=2'b01, OP_SW=2'b10.
  - State encoding.
  - Lane-select constants.
- One natural sub-module, store_lane_merge: purely combinational.
  - Inputs: op, addr[1:0], old word, new data.
  - Output: merged word.
  - Unit-testable on its own.

Test Plan:
- SW aligned: addr=0x100, data=0xDEADBEEF, 1-cycle ack -> one write, mem_addr=0x40, mem_wdata=0xDEADBEEF, done 2 cycles after accept, no read issued.
- SB all lanes: memory word=0x11223344, SB data=0x000000AA.
  - addr 0x200 -> write 0xAA223344.
  - addr 0x201 -> write 0x11AA3344.
  - addr 0x202 -> write 0x1122AA44.
  - addr 0x203 -> write 0x112233AA.
- SH both halves: old word=0x11223344, data=0xFFFFBEEF.
  - addr 0x302 -> write 0x1122BEEF.
  - addr 0x300 -> write 0xBEEF3344.
- Misalign: SH at 0x301, SW at 0x302, op=11 -> misalign pulse one cycle, mem_req never asserts, back in IDLE next cycle.
- Variable memory latency: ack delayed 4 cycles on both read and write -> mem_req, mem_we, mem_addr and mem_wdata stable throughout, busy held, single done pulse.
- Reset mid-op: reset_n low during WRITE -> mem_req=0 asynchronously, st_ready=1 after release, next SW completes normally.
